// File: rtl/mem_stage_datapath_if.sv
// Memory-stage bus: address, store operand and control from the MEM pipeline
// register, plus the extended load data and status flags back to writeback.
interface mem_stage_datapath_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              mem_wr;
  logic [1:0]        dsize;
  logic              load_ext;
  logic [31:0]       rdata;
  logic              misalign;
  logic              oor;

  modport master (
    output addr, wdata, mem_wr, dsize, load_ext,
    input  rdata, misalign, oor
  );

  modport slave (
    input  addr, wdata, mem_wr, dsize, load_ext,
    output rdata, misalign, oor
  );
endinterface

// File: rtl/mem_stage_datapath.sv
// Memory-stage data path: big-endian byte-addressed data RAM with byte/half/word
// stores, zero-latency loads with zero/sign extension, misalign and range flags.

// Generic width extender: zero- or sign-extends IN_W bits to OUT_W bits.
module mem_ext #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  input  logic             sign,
  output logic [OUT_W-1:0] dout
);
  assign dout = {{(OUT_W-IN_W){sign & din[IN_W-1]}}, din};
endmodule

// 4:1 mux indexed by access size: 0 byte, 1 half, 2 zero/reserved, 3 word.
module mem_mux4 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);
  // Plain select on the size code.
  always_comb begin
    y = d0;
    unique case (sel)
      2'b00: y = d0;
      2'b01: y = d1;
      2'b10: y = d2;
      2'b11: y = d3;
    endcase
  end
endmodule

module mem_stage_datapath #(
  parameter int SIZE   = 16384,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_datapath_if.slave  bus
);
  localparam int IDX_W = $clog2(SIZE);
  localparam logic [ADDR_W:0] SIZE_LIM = (ADDR_W+1)'(SIZE);

  // Contents are never cleared by rst; rst only gates outputs and write enables.
  logic [7:0] mem_q [SIZE];

  logic             oor_raw;
  logic [IDX_W-1:0] base_idx;
  logic [7:0]       rd_byte   [4];
  logic [31:0]      ld_byte;
  logic [31:0]      ld_half;
  logic [31:0]      ld_word;
  logic [31:0]      ld_data;
  logic [31:0]      st_byte;
  logic [31:0]      st_half;
  logic [31:0]      st_data;
  logic [31:0]      st_aligned;
  logic [1:0]       last_lane;
  logic             wr_ok;
  logic [3:0]       lane_en;
  logic [IDX_W-1:0] lane_idx  [4];
  logic [7:0]       lane_byte [4];

  assign oor_raw = {1'b0, bus.addr} >= SIZE_LIM;

  // Effective address: low bits masked for half/word; misalign only flags it.
  always_comb begin
    base_idx = bus.addr[IDX_W-1:0];
    case (bus.dsize)
      2'b01:   base_idx = {bus.addr[IDX_W-1:1], 1'b0};
      2'b11:   base_idx = {bus.addr[IDX_W-1:2], 2'b00};
      default: base_idx = bus.addr[IDX_W-1:0];
    endcase
  end

  // Four consecutive bytes from the base; index wraps, unused lanes are ignored.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    assign rd_byte[gi] = mem_q[base_idx + IDX_W'(gi)];
  end

  // Load path: big-endian assembly, extension, size select.
  mem_ext #(.IN_W(8),  .OUT_W(32)) u_ld_ext_b (.din(rd_byte[0]), .sign(bus.load_ext), .dout(ld_byte));
  mem_ext #(.IN_W(16), .OUT_W(32)) u_ld_ext_h (.din({rd_byte[0], rd_byte[1]}), .sign(bus.load_ext), .dout(ld_half));
  assign ld_word = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
  mem_mux4 #(.W(32)) u_ld_mux (.sel(bus.dsize), .d0(ld_byte), .d1(ld_half), .d2(32'h0), .d3(ld_word), .y(ld_data));

  assign bus.rdata    = (rst || oor_raw) ? 32'h0 : ld_data;
  assign bus.oor      = ~rst & oor_raw;
  assign bus.misalign = ~rst & (((bus.dsize == 2'b01) & bus.addr[0]) |
                                ((bus.dsize == 2'b11) & (bus.addr[1:0] != 2'b00)));

  // Store path: operand truncated and zero-extended, then size-selected.
  mem_ext #(.IN_W(8),  .OUT_W(32)) u_st_ext_b (.din(bus.wdata[7:0]),  .sign(1'b0), .dout(st_byte));
  mem_ext #(.IN_W(16), .OUT_W(32)) u_st_ext_h (.din(bus.wdata[15:0]), .sign(1'b0), .dout(st_half));
  mem_mux4 #(.W(32)) u_st_mux (.sel(bus.dsize), .d0(st_byte), .d1(st_half), .d2(32'h0), .d3(bus.wdata), .y(st_data));

  // Left-justify the store data so lane 0 always carries the byte at the base.
  always_comb begin
    st_aligned = st_data;
    last_lane  = 2'd0;
    case (bus.dsize)
      2'b00:   begin st_aligned = {st_data[7:0], 24'h0};  last_lane = 2'd0; end
      2'b01:   begin st_aligned = {st_data[15:0], 16'h0}; last_lane = 2'd1; end
      2'b11:   begin st_aligned = st_data;                last_lane = 2'd3; end
      default: begin st_aligned = 32'h0;                  last_lane = 2'd0; end
    endcase
  end

  // rst is combinational here, so asserting it blocks the very next edge's write.
  assign wr_ok = bus.mem_wr & ~rst & ~oor_raw & (bus.dsize != 2'b10);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_en[gi]   = wr_ok && (2'(gi) <= last_lane);
    assign lane_idx[gi]  = base_idx + IDX_W'(gi);
    assign lane_byte[gi] = st_aligned[31-8*gi -: 8];
  end

  // Byte-lane writes into the data array on the rising edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) mem_q[lane_idx[i]] <= lane_byte[i];
    end
  end
endmodule

// File: tb/tb_mem_stage_datapath.sv
// Randomized bench for mem_stage_datapath against a byte-array reference model.
module tb_mem_stage_datapath;
  localparam int SIZE   = 1024;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_datapath_if #(.ADDR_W(ADDR_W)) bus ();
  mem_stage_datapath #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] model_mem [SIZE];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a, input logic [1:0] sz, input logic ext);
    int base;
    int v;
    if (a >= SIZE) return 32'h0;
    case (sz)
      2'd0: begin
        v = model_mem[a];
        if (ext && v >= 128) v -= 256;
        return 32'(v);
      end
      2'd1: begin
        base = int'(a) - int'(a) % 2;
        v = model_mem[base] * 256 + model_mem[base+1];
        if (ext && v >= 32768) v -= 65536;
        return 32'(v);
      end
      2'd3: begin
        base = int'(a) - int'(a) % 4;
        return {model_mem[base], model_mem[base+1], model_mem[base+2], model_mem[base+3]};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_misalign(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd1 && a % 2 != 0) || (sz == 2'd3 && a % 4 != 0);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int base;
    if (a >= SIZE || sz == 2'd2) return;
    case (sz)
      2'd0: model_mem[a] = d[7:0];
      2'd1: begin
        base = int'(a) - int'(a) % 2;
        model_mem[base]   = d[15:8];
        model_mem[base+1] = d[7:0];
      end
      default: begin
        base = int'(a) - int'(a) % 4;
        model_mem[base]   = d[31:24];
        model_mem[base+1] = d[23:16];
        model_mem[base+2] = d[15:8];
        model_mem[base+3] = d[7:0];
      end
    endcase
  endfunction

  // One transaction: drive at negedge, check before and just after the edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic wr,
                       input logic [1:0] sz, input logic ext, input string tag,
                       output logic [31:0] got);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.mem_wr = wr; bus.dsize = sz; bus.load_ext = ext;
    #1;
    got = bus.rdata;
    check_val({tag, ":rd"},  bus.rdata, model_rdata(a, sz, ext));
    check_val({tag, ":mis"}, 32'(bus.misalign), 32'(model_misalign(a, sz)));
    check_val({tag, ":oor"}, 32'(bus.oor), 32'(a >= SIZE));
    @(posedge clk);
    if (wr) model_store(a, d, sz);
    #1;
    check_val({tag, ":post"}, bus.rdata, model_rdata(a, sz, ext));
    $display("op %s addr=%h sz=%0d wr=%0b ext=%0b wdata=%h rdata=%h", tag, a, sz, wr, ext, d, got);
    bus.mem_wr = 1'b0;
  endtask

  logic [31:0] g;

  initial begin
    for (int i = 0; i < SIZE; i++) model_mem[i] = 8'h0;

    // Reset held from time zero with a store pending: outputs forced to zero.
    rst = 1'b1;
    bus.addr = 32'h43; bus.wdata = 32'h99887766; bus.mem_wr = 1'b1;
    bus.dsize = 2'd3; bus.load_ext = 1'b1;
    #1;
    check_val("rst_rdata", bus.rdata, 32'h0);
    check_val("rst_mis",   32'(bus.misalign), 32'h0);
    check_val("rst_oor",   32'(bus.oor), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.mem_wr = 1'b0;
    do_op(32'h40, 32'h0, 1'b0, 2'd3, 1'b0, "rst_nowr", g);
    check_val("rst_nowr_c", g, 32'h0);

    // Word store and byte loads.
    do_op(32'h10, 32'hDEADBEEF, 1'b1, 2'd3, 1'b0, "st_w10", g);
    do_op(32'h10, 32'h0, 1'b0, 2'd3, 1'b0, "ld_w10", g);
    check_val("w10_c", g, 32'hDEADBEEF);
    do_op(32'h11, 32'h0, 1'b0, 2'd0, 1'b0, "ld_b11z", g);
    check_val("b11z_c", g, 32'h000000AD);
    do_op(32'h11, 32'h0, 1'b0, 2'd0, 1'b1, "ld_b11s", g);
    check_val("b11s_c", g, 32'hFFFFFFAD);

    // Half store and loads.
    do_op(32'h20, 32'h12348001, 1'b1, 2'd1, 1'b0, "st_h20", g);
    do_op(32'h20, 32'h0, 1'b0, 2'd1, 1'b1, "ld_h20s", g);
    check_val("h20s_c", g, 32'hFFFF8001);
    do_op(32'h20, 32'h0, 1'b0, 2'd1, 1'b0, "ld_h20z", g);
    check_val("h20z_c", g, 32'h00008001);
    do_op(32'h20, 32'h0, 1'b0, 2'd3, 1'b0, "ld_w20", g);
    check_val("w20_hi_c", {16'h0, g[31:16]}, 32'h00008001);

    // Byte store over a zero word.
    do_op(32'h33, 32'hFFFFFF7F, 1'b1, 2'd0, 1'b0, "st_b33", g);
    do_op(32'h30, 32'h0, 1'b0, 2'd3, 1'b0, "ld_w30", g);
    check_val("w30_c", g, 32'h0000007F);

    // Misaligned word load and reserved size.
    do_op(32'h13, 32'h0, 1'b0, 2'd3, 1'b0, "ld_w13", g);
    check_val("w13_c", g, 32'hDEADBEEF);
    do_op(32'h10, 32'h11111111, 1'b1, 2'd2, 1'b1, "st_rsv", g);
    check_val("rsv_c", g, 32'h0);
    do_op(32'h10, 32'h0, 1'b0, 2'd3, 1'b0, "ld_w10b", g);
    check_val("w10b_c", g, 32'hDEADBEEF);

    // Out-of-range access at the boundary.
    do_op(SIZE-1, 32'h55, 1'b1, 2'd0, 1'b0, "st_top", g);
    do_op(SIZE, 32'hA5A5A5A5, 1'b1, 2'd3, 1'b0, "st_oor", g);
    check_val("oor_rd_c", g, 32'h0);
    do_op(SIZE-1, 32'h0, 1'b0, 2'd0, 1'b0, "ld_top", g);
    check_val("top_c", g, 32'h00000055);
    do_op(32'h0, 32'h0, 1'b0, 2'd3, 1'b0, "ld_w0", g);
    check_val("w0_c", g, 32'h0);

    // Reset asserted mid-cycle during a store.
    @(negedge clk);
    bus.addr = 32'h13; bus.wdata = 32'hCAFEF00D; bus.mem_wr = 1'b1;
    bus.dsize = 2'd3; bus.load_ext = 1'b0;
    #1;
    check_val("mid_pre_rd",  bus.rdata, model_rdata(32'h13, 2'd3, 1'b0));
    check_val("mid_pre_mis", 32'(bus.misalign), 32'h1);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rd",  bus.rdata, 32'h0);
    check_val("mid_mis", 32'(bus.misalign), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.mem_wr = 1'b0;
    #1;
    check_val("mid_after",   bus.rdata, model_rdata(32'h10, 2'd3, 1'b0));
    check_val("mid_after_c", bus.rdata, 32'hDEADBEEF);
    $display("op mid_rst addr=00000013 rdata=%h", bus.rdata);

    // Randomized traffic, mostly in a small window plus the top boundary.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'(SIZE - 4 + $urandom_range(0, 8));
      else if (r == 1) a = $urandom;
      else             a = 32'($urandom_range(0, 63));
      do_op(a, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), "rnd", g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
